// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - port C, port D and RAM-side signals of the data RAM arbiter
interface ram_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdat;
  logic [DW-1:0] c_rdat;
  logic          c_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdat;
  logic [DW-1:0] d_rdat;
  logic          d_ack;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdat;
  logic [DW-1:0] ram_rdat;
  logic          ram_rd_;
  logic          ram_wr_;

  logic          busy;
  logic          owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wdat,
    input  d_req, d_we, d_addr, d_wdat,
    input  ram_rdat,
    output c_rdat, c_ack, d_rdat, d_ack,
    output ram_addr, ram_wdat, ram_rd_, ram_wr_,
    output busy, owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wdat,
    output d_req, d_we, d_addr, d_wdat,
    output ram_rdat,
    input  c_rdat, c_ack, d_rdat, d_ack,
    input  ram_addr, ram_wdat, ram_rd_, ram_wr_,
    input  busy, owner
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares the single-port SNAIL data RAM between the core (C) and debug loader (D)
module ram_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int ACC_CYC = 1,
  parameter int FAIR    = 1
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CW-1:0] ACC_LAST = CW'(ACC_CYC - 1);

  state_t        state;
  state_t        state_nxt;
  logic          pick;
  logic          acc_last;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdat;

  logic [CW-1:0] acc_cnt;
  logic          lat_we;
  logic          owner_q;
  logic          busy_q;
  logic          c_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] c_rdat_q;
  logic [DW-1:0] d_rdat_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdat_q;
  logic          ram_rd_q;
  logic          ram_wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // owner already points at the winner by the time GRANT selects its payload
  always_comb begin
    state_nxt = state;
    pick      = 1'b0;
    acc_last  = (acc_cnt == ACC_LAST);
    sel_we    = owner_q ? bus.d_we   : bus.c_we;
    sel_addr  = owner_q ? bus.d_addr : bus.c_addr;
    sel_wdat  = owner_q ? bus.d_wdat : bus.c_wdat;
    case (state)
      IDLE: begin
        if (bus.c_req && bus.d_req) begin
          pick      = (FAIR != 0) ? !owner_q : 1'b0;
          state_nxt = GRANT;
        end else if (bus.c_req) begin
          pick      = 1'b0;
          state_nxt = GRANT;
        end else if (bus.d_req) begin
          pick      = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        state_nxt = ACC;
      end
      ACC: begin
        if (acc_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt    <= '0;
      lat_we     <= 1'b0;
      owner_q    <= 1'b1;
      busy_q     <= 1'b0;
      c_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      c_rdat_q   <= '0;
      d_rdat_q   <= '0;
      ram_addr_q <= '0;
      ram_wdat_q <= '0;
      ram_rd_q   <= 1'b1;
      ram_wr_q   <= 1'b1;
    end else begin
      c_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      busy_q  <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (state_nxt == GRANT) begin
            owner_q <= pick;
          end
        end
        GRANT: begin
          lat_we     <= sel_we;
          ram_addr_q <= sel_addr;
          ram_wdat_q <= sel_wdat;
          ram_rd_q   <= sel_we;
          ram_wr_q   <= !sel_we;
          acc_cnt    <= '0;
        end
        ACC: begin
          if (acc_last) begin
            ram_rd_q <= 1'b1;
            ram_wr_q <= 1'b1;
            // read data is sampled while the strobe is still low
            if (!lat_we) begin
              if (owner_q) begin
                d_rdat_q <= bus.ram_rdat;
              end else begin
                c_rdat_q <= bus.ram_rdat;
              end
            end
            if (owner_q) begin
              d_ack_q <= 1'b1;
            end else begin
              c_ack_q <= 1'b1;
            end
          end else begin
            acc_cnt <= acc_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.c_rdat   = c_rdat_q;
  assign bus.c_ack    = c_ack_q;
  assign bus.d_rdat   = d_rdat_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_wdat = ram_wdat_q;
  assign bus.ram_rd_  = ram_rd_q;
  assign bus.ram_wr_  = ram_wr_q;
  assign bus.busy     = busy_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - bench for ram_port_arbiter: fair/ACC_CYC=1 and fixed-priority/ACC_CYC=3 instances
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_clr = 1'b1;
  always #5 clk = ~clk;

  // [dut][port], port 0 = C, port 1 = D
  logic       req  [2][2];
  logic       we   [2][2];
  logic [7:0] addr [2][2];
  logic [7:0] wdat [2][2];
  logic [7:0] rdat [2][2];
  logic       ack  [2][2];
  logic [7:0] ram_addr [2];
  logic [7:0] ram_wdat [2];
  logic       ram_rd_n [2];
  logic       ram_wr_n [2];
  logic       busy     [2];
  logic       owner    [2];
  logic [7:0] mem [2][256];

  function automatic int acc_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit fair_of(input int i);
    return (i == 0);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ram_port_arbiter_if #(.AW(8), .DW(8)) bus ();
    assign bus.c_req    = req[gi][0];
    assign bus.c_we     = we[gi][0];
    assign bus.c_addr   = addr[gi][0];
    assign bus.c_wdat   = wdat[gi][0];
    assign bus.d_req    = req[gi][1];
    assign bus.d_we     = we[gi][1];
    assign bus.d_addr   = addr[gi][1];
    assign bus.d_wdat   = wdat[gi][1];
    assign bus.ram_rdat = mem[gi][bus.ram_addr];
    assign rdat[gi][0]  = bus.c_rdat;
    assign ack[gi][0]   = bus.c_ack;
    assign rdat[gi][1]  = bus.d_rdat;
    assign ack[gi][1]   = bus.d_ack;
    assign ram_addr[gi] = bus.ram_addr;
    assign ram_wdat[gi] = bus.ram_wdat;
    assign ram_rd_n[gi] = bus.ram_rd_;
    assign ram_wr_n[gi] = bus.ram_wr_;
    assign busy[gi]     = bus.busy;
    assign owner[gi]    = bus.owner;

    ram_port_arbiter #(
      .AW(8), .DW(8), .ACC_CYC((gi == 0) ? 1 : 3), .FAIR((gi == 0) ? 1 : 0)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_clr) begin
        for (int a = 0; a < 256; a++) mem[i][a] <= 8'h00;
      end else if (ram_wr_n[i] === 1'b0) begin
        mem[i][ram_addr[i]] <= ram_wdat[i];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: one access at a time, decided in an idle cycle g,
  // payload taken in g+1, strobes in g+2..g+1+ACC, ack at g+2+ACC, idle again at g+3+ACC.
  int         cyc = 0;
  int         next_free [2];
  int         g_cyc     [2];
  int         g_port    [2];
  logic       g_we      [2];
  logic [7:0] g_addr    [2];
  logic [7:0] g_wdat    [2];
  logic [7:0] g_rd      [2];
  logic       m_owner   [2];
  logic [7:0] m_rdat    [2][2];
  logic [7:0] shadow    [2][256];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      next_free[i] = cyc;
      g_cyc[i]     = -100;
      m_owner[i]   = 1'b1;
      m_rdat[i][0] = 8'h00;
      m_rdat[i][1] = 8'h00;
    end
  endtask

  task automatic model_sample(input int i);
    int w;
    if (g_cyc[i] >= 0 && cyc == g_cyc[i] + 1) begin
      g_we[i]   = we[i][g_port[i]];
      g_addr[i] = addr[i][g_port[i]];
      g_wdat[i] = wdat[i][g_port[i]];
      if (g_we[i]) shadow[i][g_addr[i]] = g_wdat[i];
      else         g_rd[i] = shadow[i][g_addr[i]];
    end
    if (cyc >= next_free[i] && (req[i][0] || req[i][1])) begin
      if (req[i][0] && req[i][1]) w = (fair_of(i) && !m_owner[i]) ? 1 : 0;
      else                        w = req[i][1] ? 1 : 0;
      g_cyc[i]     = cyc;
      g_port[i]    = w;
      m_owner[i]   = (w == 1);
      next_free[i] = cyc + 3 + acc_of(i);
    end
  endtask

  task automatic model_check(input int i);
    int ph;
    bit acc_now, done_now, busy_now;
    ph       = cyc - g_cyc[i];
    acc_now  = (g_cyc[i] >= 0) && ph >= 2 && ph <= 1 + acc_of(i);
    done_now = (g_cyc[i] >= 0) && ph == 2 + acc_of(i);
    busy_now = (g_cyc[i] >= 0) && ph >= 1 && ph <= 2 + acc_of(i);
    if (done_now && !g_we[i]) m_rdat[i][g_port[i]] = g_rd[i];
    check($sformatf("busy%0d", i), busy[i], busy_now);
    check($sformatf("rd_n%0d", i), ram_rd_n[i], !(acc_now && !g_we[i]));
    check($sformatf("wr_n%0d", i), ram_wr_n[i], !(acc_now && g_we[i]));
    check($sformatf("not_both_low%0d", i), ram_rd_n[i] | ram_wr_n[i], 1);
    if (acc_now) check($sformatf("ram_addr%0d", i), ram_addr[i], g_addr[i]);
    if (acc_now && g_we[i]) check($sformatf("ram_wdat%0d", i), ram_wdat[i], g_wdat[i]);
    for (int p = 0; p < 2; p++) begin
      check($sformatf("ack%0d_%0d", i, p), ack[i][p], done_now && g_port[i] == p);
      check($sformatf("rdat%0d_%0d", i, p), rdat[i][p], m_rdat[i][p]);
    end
    check($sformatf("owner%0d", i), owner[i], m_owner[i]);
  endtask

  task automatic tick();
    bit r;
    r = rst;
    if (!r) for (int i = 0; i < 2; i++) model_sample(i);
    @(posedge clk);
    #1;
    cyc++;
    if (r) model_reset();
    for (int i = 0; i < 2; i++) model_check(i);
  endtask

  function automatic bit acked(input int i, input int p);
    return g_cyc[i] >= 0 && g_port[i] == p && cyc == g_cyc[i] + 2 + acc_of(i);
  endfunction

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (cyc < next_free[i] && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic do_access(input int i, input int p, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input bit chg, input logic [7:0] alt,
                           output int lat, output int strb, output logic [7:0] rd);
    bit done;
    done = 0;
    lat  = 0;
    strb = 0;
    rd   = 8'h00;
    req[i][p] = 1'b1; we[i][p] = w; addr[i][p] = a; wdat[i][p] = d;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (ram_wr_n[i] === 1'b0 || ram_rd_n[i] === 1'b0) strb++;
      if (chg && lat == 2) addr[i][p] = alt;
      if (ack[i][p] === 1'b1) begin
        done = 1;
        rd = rdat[i][p];
        req[i][p] = 1'b0;
      end
    end
    req[i][p] = 1'b0;
    check("ack_seen", done, 1);
  endtask

  task automatic drive_rand(input int i, input int p);
    bit owned;
    owned = g_cyc[i] >= 0 && g_port[i] == p && cyc > g_cyc[i] && cyc <= g_cyc[i] + 2 + acc_of(i);
    if (acked(i, p)) begin
      req[i][p] = ($urandom_range(1, 0) == 1);
      we[i][p] = ($urandom_range(1, 0) == 1);
      addr[i][p] = 8'($urandom_range(15, 0));
      wdat[i][p] = 8'($urandom);
    end else if (req[i][p]) begin
      if (!owned && $urandom_range(15, 0) == 0) req[i][p] = 1'b0;
      else if (owned && cyc >= g_cyc[i] + 2 && $urandom_range(7, 0) == 0) req[i][p] = 1'b0;
      else if ($urandom_range(7, 0) == 0) begin
        addr[i][p] = 8'($urandom_range(15, 0));
        wdat[i][p] = 8'($urandom);
      end
    end else if ($urandom_range(3, 0) == 0) begin
      req[i][p] = 1'b1;
      we[i][p] = ($urandom_range(1, 0) == 1);
      addr[i][p] = 8'($urandom_range(15, 0));
      wdat[i][p] = 8'($urandom);
    end
  endtask

  initial begin
    int lat, strb, n, dcnt;
    logic [7:0] rd;
    int seq[$];

    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = 8'h00; wdat[i][p] = 8'h00;
      end
      for (int a = 0; a < 256; a++) shadow[i][a] = 8'h00;
    end
    model_reset();

    // reset held for two cycles
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_rd_n", ram_rd_n[i], 1);
      check("rst_wr_n", ram_wr_n[i], 1);
      check("rst_c_ack", ack[i][0], 0);
      check("rst_d_ack", ack[i][1], 0);
      check("rst_busy", busy[i], 0);
      check("rst_owner", owner[i], 1);
      check("rst_ram_addr", ram_addr[i], 0);
      check("rst_ram_wdat", ram_wdat[i], 0);
      check("rst_c_rdat", rdat[i][0], 0);
      check("rst_d_rdat", rdat[i][1], 0);
    end
    rst = 1'b0;
    ram_clr = 1'b0;

    // C write then read back, both strobe lengths
    wait_idle(0);
    do_access(0, 0, 1'b1, 8'h05, 8'h41, 1'b0, 8'h00, lat, strb, rd);
    check("t2_wr_lat", lat, 3);
    check("t2_wr_strb", strb, 1);
    wait_idle(0);
    do_access(0, 0, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, lat, strb, rd);
    check("t2_rd_lat", lat, 3);
    check("t2_rd_data", rd, 8'h41);
    wait_idle(1);
    do_access(1, 1, 1'b1, 8'h33, 8'hC3, 1'b0, 8'h00, lat, strb, rd);
    check("acc3_wr_lat", lat, 5);
    check("acc3_wr_strb", strb, 3);
    wait_idle(1);
    do_access(1, 0, 1'b0, 8'h33, 8'h00, 1'b0, 8'h00, lat, strb, rd);
    check("acc3_rd_lat", lat, 5);
    check("acc3_rd_data", rd, 8'hC3);

    // continuous contention on the fair instance
    wait_idle(0);
    req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 8'h01; wdat[0][0] = 8'($urandom);
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 8'h02; wdat[0][1] = 8'($urandom);
    n = 0;
    while (seq.size() < 8 && n < 80) begin
      tick();
      n++;
      for (int p = 0; p < 2; p++) begin
        if (ack[0][p] === 1'b1) begin
          seq.push_back(p);
          wdat[0][p] = 8'($urandom);
        end
      end
    end
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    check("t3_count", seq.size(), 8);
    for (int k = 1; k < seq.size(); k++) check("t3_alternate", seq[k] ^ seq[k-1], 1);

    // continuous contention on the fixed-priority instance
    wait_idle(1);
    seq.delete();
    dcnt = 0;
    req[1][0] = 1'b1; we[1][0] = 1'b1; addr[1][0] = 8'h01; wdat[1][0] = 8'($urandom);
    req[1][1] = 1'b1; we[1][1] = 1'b1; addr[1][1] = 8'h02; wdat[1][1] = 8'($urandom);
    n = 0;
    while (seq.size() < 6 && n < 100) begin
      tick();
      n++;
      if (ack[1][0] === 1'b1) seq.push_back(0);
      if (ack[1][1] === 1'b1) dcnt++;
    end
    req[1][0] = 1'b0;
    req[1][1] = 1'b0;
    check("t4_c_grants", seq.size(), 6);
    check("t4_d_grants", dcnt, 0);

    // payload change after grant is ignored
    wait_idle(0);
    do_access(0, 1, 1'b1, 8'h10, 8'h5A, 1'b0, 8'h00, lat, strb, rd);
    wait_idle(0);
    do_access(0, 1, 1'b1, 8'h20, 8'hA5, 1'b0, 8'h00, lat, strb, rd);
    wait_idle(0);
    do_access(0, 1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h20, lat, strb, rd);
    check("t5_d_rdat", rd, 8'h5A);

    // reset during the access phase of a D read
    wait_idle(0);
    wait_idle(1);
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 8'h10;
    tick();
    tick();
    check("t6_in_acc", ram_rd_n[0], 0);
    rst = 1'b1;
    req[0][1] = 1'b0;
    tick();
    check("t6_no_dack", ack[0][1], 0);
    check("t6_rd_n", ram_rd_n[0], 1);
    check("t6_wr_n", ram_wr_n[0], 1);
    check("t6_busy", busy[0], 0);
    rst = 1'b0;
    do_access(0, 0, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, lat, strb, rd);
    check("t6_c_rdat", rd, 8'h41);
    check("t6_c_lat", lat, 3);

    // randomized traffic on both instances
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) drive_rand(i, p);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      req[i][0] = 1'b0;
      req[i][1] = 1'b0;
    end
    for (int k = 0; k < 10; k++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
